pc_sequencer: RTL and testbench



---
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundles the sequencer's memory, datapath, PC and status signals.
// master = sequencer side, slave = surrounding system (PC, imem, datapath).
interface pc_sequencer_if #(
   parameter int ADDR_W  = 11,
   parameter int INSTR_W = 32
);
   logic               mem_req;
   logic               mem_ack;
   logic [INSTR_W-1:0] mem_data;
   logic               zero_flag;
   logic               exec_start;
   logic               exec_done;
   logic [INSTR_W-1:0] instr;
   logic [1:0]         pc_flag;
   logic [ADDR_W-1:0]  NEnd_linha;
   logic [ADDR_W-1:0]  NEnd_coluna;
   logic               halted;
   logic               fault;
   logic               resume;
   logic [15:0]        instr_count;

   modport master (
      output mem_req, exec_start, instr, pc_flag, NEnd_linha, NEnd_coluna,
             halted, fault, instr_count,
      input  mem_ack, mem_data, zero_flag, exec_done, resume
   );

   modport slave (
      input  mem_req, exec_start, instr, pc_flag, NEnd_linha, NEnd_coluna,
             halted, fault, instr_count,
      output mem_ack, mem_data, zero_flag, exec_done, resume
   );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencing FSM: fetch over req/ack, decode, optional datapath execute,
// then exactly one PC advance/jump per retired instruction.
module pc_sequencer #(
   parameter int ADDR_W  = 11,
   parameter int INSTR_W = 32,
   parameter int TIMEOUT = 255
) (
   input  logic           clock,
   input  logic           resetCPU,
   pc_sequencer_if.master bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_JMP = 4'b0001;
   localparam logic [3:0] OP_JZ  = 4'b0010;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [1:0] PC_ADV  = 2'b00;
   localparam logic [1:0] PC_JMP  = 2'b01;
   localparam logic [1:0] PC_HOLD = 2'b10;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_UPDATE, S_HALT} state_t;

   state_t             state_q;
   logic               mem_req_q, exec_start_q, halted_q, fault_q;
   logic [INSTR_W-1:0] instr_q;
   logic [1:0]         pc_flag_q;
   logic [ADDR_W-1:0]  row_q, col_q;
   logic [15:0]        cnt_q;
   logic [TW-1:0]      timer_q;

   logic [3:0]        opcode;
   logic [ADDR_W-1:0] tgt_row, tgt_col;
   assign opcode  = instr_q[INSTR_W-1 -: 4];
   assign tgt_row = instr_q[2*ADDR_W-1:ADDR_W];
   assign tgt_col = instr_q[ADDR_W-1:0];

   // Outputs are set from the next state, so pc_flag only leaves HOLD
   // in the single cycle spent in UPDATE.
   always_ff @(posedge clock or posedge resetCPU) begin
      if (resetCPU) begin
         state_q      <= S_FETCH;
         mem_req_q    <= 1'b0;
         exec_start_q <= 1'b0;
         halted_q     <= 1'b0;
         fault_q      <= 1'b0;
         instr_q      <= '0;
         pc_flag_q    <= PC_HOLD;
         row_q        <= '0;
         col_q        <= '0;
         cnt_q        <= '0;
         timer_q      <= '0;
      end else begin
         mem_req_q    <= 1'b0;
         exec_start_q <= 1'b0;
         pc_flag_q    <= PC_HOLD;
         case (state_q)
            S_FETCH: begin
               if (bus.mem_ack) begin
                  instr_q <= bus.mem_data;
                  timer_q <= '0;
                  state_q <= S_DECODE;
               end else if (timer_q == TW'(TIMEOUT - 1)) begin
                  timer_q  <= '0;
                  fault_q  <= 1'b1;
                  halted_q <= 1'b1;
                  state_q  <= S_HALT;
               end else begin
                  timer_q   <= timer_q + 1'b1;
                  mem_req_q <= 1'b1;
               end
            end
            S_DECODE: begin
               if (opcode == OP_JMP || (opcode == OP_JZ && bus.zero_flag)) begin
                  row_q     <= tgt_row;
                  col_q     <= tgt_col;
                  pc_flag_q <= PC_JMP;
                  state_q   <= S_UPDATE;
               end else if (opcode == OP_JZ || opcode == OP_NOP) begin
                  pc_flag_q <= PC_ADV;
                  state_q   <= S_UPDATE;
               end else if (opcode == OP_HLT) begin
                  halted_q <= 1'b1;
                  state_q  <= S_HALT;
               end else begin
                  exec_start_q <= 1'b1;
                  state_q      <= S_EXEC;
               end
            end
            S_EXEC: begin
               // exec_start_q marks the first EXEC cycle; done there is ignored.
               if (bus.exec_done && !exec_start_q) begin
                  pc_flag_q <= PC_ADV;
                  state_q   <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
               mem_req_q <= 1'b1;
               state_q   <= S_FETCH;
            end
            S_HALT: begin
               if (bus.resume && !fault_q) begin
                  halted_q  <= 1'b0;
                  pc_flag_q <= PC_ADV;
                  state_q   <= S_UPDATE;
               end
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign bus.mem_req     = mem_req_q;
   assign bus.exec_start  = exec_start_q;
   assign bus.instr       = instr_q;
   assign bus.pc_flag     = pc_flag_q;
   assign bus.NEnd_linha  = row_q;
   assign bus.NEnd_coluna = col_q;
   assign bus.halted      = halted_q;
   assign bus.fault       = fault_q;
   assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (TIMEOUT=4): NOP, JMP, JZ, ALU, HLT/resume,
// fetch timeout and asynchronous reset.
module tb_pc_sequencer;
   logic clock = 1'b0;
   logic resetCPU;
   int   tests = 0;
   int   fails = 0;

   always #5 clock = ~clock;

   pc_sequencer_if #(.ADDR_W(11), .INSTR_W(32)) bus ();

   pc_sequencer #(.ADDR_W(11), .INSTR_W(32), .TIMEOUT(4)) dut (
      .clock    (clock),
      .resetCPU (resetCPU),
      .bus      (bus)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Waits (bounded) for mem_req, then acks one instruction; returns in DECODE.
   task automatic fetch(input logic [31:0] d);
      int n = 0;
      while (!bus.mem_req && n < 20) begin step(); n++; end
      tests++;
      if (bus.mem_req !== 1'b1) begin
         $display("FAIL fetch_wait mem_req got %b want 1", bus.mem_req);
         fails++;
      end
      bus.mem_ack = 1'b1; bus.mem_data = d;
      step();
      bus.mem_ack = 1'b0; bus.mem_data = '0;
   endtask

   task automatic test_reset();
      resetCPU = 1'b1;
      bus.mem_ack = 0; bus.mem_data = '0; bus.zero_flag = 0;
      bus.exec_done = 0; bus.resume = 0;
      #12;
      tests++;
      if ({bus.mem_req, bus.exec_start, bus.pc_flag, bus.halted, bus.fault} !== 6'b00_10_00) begin
         $display("FAIL reset_ctrl got %b want 001000",
                  {bus.mem_req, bus.exec_start, bus.pc_flag, bus.halted, bus.fault});
         fails++;
      end
      tests++;
      if ({bus.instr, bus.NEnd_linha, bus.NEnd_coluna, bus.instr_count} !== '0) begin
         $display("FAIL reset_data instr=%h row=%h col=%h cnt=%0d want all 0",
                  bus.instr, bus.NEnd_linha, bus.NEnd_coluna, bus.instr_count);
         fails++;
      end
      @(posedge clock); #1 resetCPU = 1'b0;
      step();
      tests++;
      if (bus.mem_req !== 1'b1) begin
         $display("FAIL reset_first_req got %b want 1", bus.mem_req);
         fails++;
      end
   endtask

   task automatic test_nop();
      fetch(32'h0000_0000);
      tests++;
      if ({bus.mem_req, bus.pc_flag} !== 3'b0_10) begin
         $display("FAIL nop_decode req/flag got %b want 010", {bus.mem_req, bus.pc_flag});
         fails++;
      end
      step();
      tests++;
      if (bus.pc_flag !== 2'b00) begin
         $display("FAIL nop_update flag got %b want 00", bus.pc_flag);
         fails++;
      end
      step();
      tests++;
      if ({bus.pc_flag, bus.mem_req} !== 3'b10_1 || bus.instr_count !== 16'd1) begin
         $display("FAIL nop_after flag=%b req=%b cnt=%0d want 10 1 1",
                  bus.pc_flag, bus.mem_req, bus.instr_count);
         fails++;
      end
   endtask

   task automatic test_jmp();
      fetch(32'h1000_0000 | (32'd3 << 11) | 32'h7FF);
      tests++;
      if (bus.pc_flag !== 2'b10) begin
         $display("FAIL jmp_decode flag got %b want 10", bus.pc_flag);
         fails++;
      end
      step();
      tests++;
      if (bus.pc_flag !== 2'b01 || bus.NEnd_linha !== 11'd3 || bus.NEnd_coluna !== 11'h7FF) begin
         $display("FAIL jmp_update flag=%b row=%h col=%h want 01 003 7ff",
                  bus.pc_flag, bus.NEnd_linha, bus.NEnd_coluna);
         fails++;
      end
      step();
      tests++;
      if (bus.pc_flag !== 2'b10 || bus.instr_count !== 16'd2) begin
         $display("FAIL jmp_after flag=%b cnt=%0d want 10 2", bus.pc_flag, bus.instr_count);
         fails++;
      end
   endtask

   task automatic test_jz();
      bus.zero_flag = 1'b0;
      fetch(32'h2000_0000 | (32'd5 << 11) | 32'd9);
      step();
      tests++;
      if (bus.pc_flag !== 2'b00 || bus.NEnd_linha !== 11'd3 || bus.NEnd_coluna !== 11'h7FF) begin
         $display("FAIL jz_not_taken flag=%b row=%h col=%h want 00 003 7ff",
                  bus.pc_flag, bus.NEnd_linha, bus.NEnd_coluna);
         fails++;
      end
      step();
      bus.zero_flag = 1'b1;
      fetch(32'h2000_0000 | (32'd5 << 11) | 32'd9);
      step();
      tests++;
      if (bus.pc_flag !== 2'b01 || bus.NEnd_linha !== 11'd5 || bus.NEnd_coluna !== 11'd9) begin
         $display("FAIL jz_taken flag=%b row=%h col=%h want 01 005 009",
                  bus.pc_flag, bus.NEnd_linha, bus.NEnd_coluna);
         fails++;
      end
      bus.zero_flag = 1'b0;
      step();
      tests++;
      if (bus.instr_count !== 16'd4) begin
         $display("FAIL jz_count got %0d want 4", bus.instr_count);
         fails++;
      end
   endtask

   task automatic test_alu();
      fetch(32'h3000_00AB);
      step();
      tests++;
      if (bus.exec_start !== 1'b1 || bus.instr !== 32'h3000_00AB) begin
         $display("FAIL alu_start start=%b instr=%h want 1 300000ab", bus.exec_start, bus.instr);
         fails++;
      end
      bus.exec_done = 1'b1;
      step();
      tests++;
      if (bus.exec_start !== 1'b0 || bus.pc_flag !== 2'b10) begin
         $display("FAIL alu_pulse start=%b flag=%b want 0 10", bus.exec_start, bus.pc_flag);
         fails++;
      end
      step();
      tests++;
      if (bus.pc_flag !== 2'b00) begin
         $display("FAIL alu_update flag got %b want 00", bus.pc_flag);
         fails++;
      end
      bus.exec_done = 1'b0;
      step();
      // done only during the start cycle must not retire the instruction
      fetch(32'h4000_0001);
      step();
      bus.exec_done = 1'b1;
      step();
      bus.exec_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (bus.pc_flag !== 2'b10 || bus.exec_start !== 1'b0) begin
            $display("FAIL alu_coincident cyc%0d flag=%b start=%b want 10 0",
                     i, bus.pc_flag, bus.exec_start);
            fails++;
         end
         step();
      end
      bus.exec_done = 1'b1;
      step();
      bus.exec_done = 1'b0;
      tests++;
      if (bus.pc_flag !== 2'b00) begin
         $display("FAIL alu_late_done flag got %b want 00", bus.pc_flag);
         fails++;
      end
      step();
      tests++;
      if (bus.instr_count !== 16'd6) begin
         $display("FAIL alu_count got %0d want 6", bus.instr_count);
         fails++;
      end
   endtask

   task automatic test_halt();
      fetch(32'hF000_0000);
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (bus.halted !== 1'b1 || bus.pc_flag !== 2'b10 || bus.mem_req !== 1'b0) begin
            $display("FAIL halt_hold cyc%0d halted=%b flag=%b req=%b want 1 10 0",
                     i, bus.halted, bus.pc_flag, bus.mem_req);
            fails++;
         end
      end
      bus.resume = 1'b1;
      step();
      bus.resume = 1'b0;
      tests++;
      if (bus.pc_flag !== 2'b00 || bus.halted !== 1'b0) begin
         $display("FAIL halt_resume flag=%b halted=%b want 00 0", bus.pc_flag, bus.halted);
         fails++;
      end
      step();
      tests++;
      if (bus.mem_req !== 1'b1 || bus.pc_flag !== 2'b10 || bus.instr_count !== 16'd7) begin
         $display("FAIL halt_refetch req=%b flag=%b cnt=%0d want 1 10 7",
                  bus.mem_req, bus.pc_flag, bus.instr_count);
         fails++;
      end
   endtask

   // Entered here on the first FETCH cycle after an UPDATE.
   task automatic test_timeout();
      step(); step(); step();
      tests++;
      if (bus.fault !== 1'b0 || bus.halted !== 1'b0 || bus.mem_req !== 1'b1) begin
         $display("FAIL timeout_early fault=%b halted=%b req=%b want 0 0 1",
                  bus.fault, bus.halted, bus.mem_req);
         fails++;
      end
      step();
      tests++;
      if (bus.fault !== 1'b1 || bus.halted !== 1'b1 || bus.mem_req !== 1'b0) begin
         $display("FAIL timeout_fault fault=%b halted=%b req=%b want 1 1 0",
                  bus.fault, bus.halted, bus.mem_req);
         fails++;
      end
      bus.resume = 1'b1;
      step(); step();
      bus.resume = 1'b0;
      tests++;
      if (bus.halted !== 1'b1 || bus.pc_flag !== 2'b10 || bus.fault !== 1'b1 ||
          bus.instr_count !== 16'd7) begin
         $display("FAIL timeout_resume halted=%b flag=%b fault=%b cnt=%0d want 1 10 1 7",
                  bus.halted, bus.pc_flag, bus.fault, bus.instr_count);
         fails++;
      end
   endtask

   task automatic test_async_reset();
      #2 resetCPU = 1'b1;
      #1;
      tests++;
      if (bus.fault !== 1'b0 || bus.halted !== 1'b0 || bus.instr_count !== 16'd0) begin
         $display("FAIL areset_halt fault=%b halted=%b cnt=%0d want 0 0 0",
                  bus.fault, bus.halted, bus.instr_count);
         fails++;
      end
      @(posedge clock); #1 resetCPU = 1'b0;
      fetch(32'h1000_0000 | (32'd3 << 11) | 32'h7FF);
      step(); step();
      step();
      // now mid-FETCH with req high, target loaded and count=1
      #2 resetCPU = 1'b1;
      #1;
      tests++;
      if ({bus.mem_req, bus.exec_start, bus.pc_flag, bus.halted, bus.fault} !== 6'b00_10_00 ||
          {bus.instr, bus.NEnd_linha, bus.NEnd_coluna, bus.instr_count} !== '0) begin
         $display("FAIL areset_fetch req=%b flag=%b row=%h col=%h instr=%h cnt=%0d want 0 10 0 0 0 0",
                  bus.mem_req, bus.pc_flag, bus.NEnd_linha, bus.NEnd_coluna, bus.instr,
                  bus.instr_count);
         fails++;
      end
      @(posedge clock); #1 resetCPU = 1'b0;
      step();
      tests++;
      if (bus.mem_req !== 1'b1) begin
         $display("FAIL areset_release req got %b want 1", bus.mem_req);
         fails++;
      end
   endtask

   initial begin
      test_reset();
      test_nop();
      test_jmp();
      test_jz();
      test_alu();
      test_halt();
      test_timeout();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
